rf_mp: RTL
==========

Name: rf_mp

Overview:
Parametrised multi-port register file, the next generation of the core's single-write/dual-read RF. Supports configurable width, depth and read-port count, plus two write ports with fixed priority. Adds optional write-to-read bypass, a per-register busy scoreboard for multicycle producers, and a soft-clear sweep FSM. Sits between decode (reads, issue) and writeback (writes) in the pipelined core.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of registers (power of 2, >=4); AW = clog2(NREG) is a derived localparam
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
ra  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
rd  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
rbusy  out  NRD  scoreboard busy bit of the register addressed by each read port
we0  in  1  write enable, port 0
wa0  in  AW  write address, port 0
wd0  in  XLEN  write data, port 0
we1  in  1  write enable, port 1 (higher priority)
wa1  in  AW  write address, port 1
wd1  in  XLEN  write data, port 1
iss_v  in  1  issue: mark register iss_a busy
iss_a  in  AW  issue destination register
clr_req  in  1  start soft-clear sweep (pulse)
clr_busy  out  1  high while the sweep is running

Behaviour:
- Reset (async, any time, including mid-sweep): all registers = 0, all busy bits = 0, FSM -> IDLE, clr_busy = 0. Outputs derive combinationally from zeroed state, so rd = 0 and rbusy = 0.
- Read: combinational, zero latency. rd[k] = reg[ra[k]]; rbusy[k] = busy[ra[k]].
- ZERO_REG=1: reads of address 0 return 0 and rbusy 0 regardless of writes, bypass or issue. Writes and issues to address 0 are dropped.
- Write: on the rising edge, a port with weN=1 updates reg[waN] <= wdN. If we0 and we1 both target the same address, port 1 wins. Different addresses are both written in the same cycle.
- BYPASS=1: if a write port is active this cycle and its address equals ra[k] (and is not address 0 with ZERO_REG=1), rd[k] = that wd, with port 1 over port 0. BYPASS=0: rd shows the old value until the next cycle.
- Scoreboard: a write on either port clears busy[wa]. iss_v sets busy[iss_a].
  - Issue and write to the same register in the same cycle: set wins, so busy = 1.
  - rbusy is not bypassed: it reflects the registered busy state only.
- Soft-clear FSM:
  - States are IDLE and SWEEP, with a counter cnt of AW bits.
  - IDLE: clr_req=1 -> SWEEP, cnt <= 0, clr_busy <= 1 (registered, high from the next cycle).
  - SWEEP: each cycle reg[cnt] <= 0 and busy[cnt] <= 0, then cnt <= cnt+1. When cnt == NREG-1 it clears that entry and returns to IDLE with clr_busy <= 0. The sweep lasts exactly NREG cycles.
  - In SWEEP, we0, we1 and iss_v are ignored (dropped, not queued), and clr_req is ignored.
  - Reads remain legal during SWEEP and return current contents. Bypass is disabled during SWEEP.
- No X propagation: all state reset; unused address bits cannot occur because NREG is a power of 2.

Test Plan:
- Reset and basic R/W: assert reset; write 0xDEADBEEF to r5 via port 0, then read r5 on ports 0 and 1 -> rd = 0xDEADBEEF on both; r0 write of 0x1234 -> reads 0.
- Dual-write conflict: we0/we1 both target r7 with 0x11111111 and 0x22222222 -> r7 = 0x22222222. Then r3 = 0xA and r4 = 0xB in the same cycle -> both written.
- Bypass: BYPASS=1, ra[0] = 9 while we1 writes 0xCAFE0009 to r9 -> rd[0] = 0xCAFE0009 in the same cycle. BYPASS=0 build -> old value, new value next cycle.
- Scoreboard: iss_v on r12 -> rbusy = 1 next cycle. Write r12 -> rbusy = 0. Same-cycle issue and write on r12 -> rbusy stays 1.
- Soft clear: fill r1..r31 with non-zero values and pulse clr_req -> clr_busy high for exactly 32 cycles, all reads 0 after. A we0 to r2 mid-sweep is dropped.
- Reset mid-sweep: assert reset at sweep cycle 10 -> clr_busy = 0 immediately, all registers 0. A new clr_req afterwards runs a full 32-cycle sweep.

Source files
------------

// File: rtl/rf_mp.sv
// rf_mp -- parametrised multi-port register file.
//
// Two write ports (port 1 has priority on an address collision), NRD
// combinational read ports, optional same-cycle write-to-read bypass, a
// per-register busy scoreboard for multicycle producers and a soft-clear
// sweep that zeroes one register per cycle.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   ra / rd / rbusy   read address, data and busy bit; port k uses slice k
//   we0/wa0/wd0       write port 0
//   we1/wa1/wd1       write port 1 (wins over port 0 on the same address)
//   iss_v / iss_a     issue: mark register iss_a busy
//   clr_req           start a soft-clear sweep (ignored while one runs)
//   clr_busy          high while the sweep is running
module rf_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NRD*$clog2(NREG)-1:0]   ra,
  output logic [NRD*XLEN-1:0]           rd,
  output logic [NRD-1:0]                rbusy,
  input  logic                          we0,
  input  logic [$clog2(NREG)-1:0]       wa0,
  input  logic [XLEN-1:0]               wd0,
  input  logic                          we1,
  input  logic [$clog2(NREG)-1:0]       wa1,
  input  logic [XLEN-1:0]               wd1,
  input  logic                          iss_v,
  input  logic [$clog2(NREG)-1:0]       iss_a,
  input  logic                          clr_req,
  output logic                          clr_busy
);

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic sweeping;
  logic w0_ok;
  logic w1_ok;
  logic iss_ok;

  assign sweeping = (state == SWEEP);

  // Qualified requests: everything is dropped during a sweep, and register 0
  // is never written or marked busy when it is hardwired to zero.
  assign w0_ok  = we0   && !sweeping && !((ZERO_REG != 0) && (wa0   == '0));
  assign w1_ok  = we1   && !sweeping && !((ZERO_REG != 0) && (wa1   == '0));
  assign iss_ok = iss_v && !sweeping && !((ZERO_REG != 0) && (iss_a == '0));

  // Writes retire producers first, then an issue re-marks its target, so a
  // same-cycle issue and write to one register leaves it busy.
  always_comb begin
    busy_nxt = busy;
    if (w0_ok)  busy_nxt[wa0]   = 1'b0;
    if (w1_ok)  busy_nxt[wa1]   = 1'b0;
    if (iss_ok) busy_nxt[iss_a] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      busy     <= '0;
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (state == IDLE) begin
      if (clr_req) begin
        state    <= SWEEP;
        cnt      <= '0;
        clr_busy <= 1'b1;
      end
      // Port 1 is written last so it wins an address collision.
      if (w0_ok) mem[wa0] <= wd0;
      if (w1_ok) mem[wa1] <= wd1;
      busy <= busy_nxt;
    end else begin
      mem[cnt]  <= '0;
      busy[cnt] <= 1'b0;
      cnt       <= cnt + AW'(1);
      if (cnt == LAST) begin
        state    <= IDLE;
        clr_busy <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            is_r0;

    assign a     = ra[k*AW +: AW];
    assign is_r0 = (ZERO_REG != 0) && (a == '0);

    // w0_ok/w1_ok are already false during a sweep, which disables bypass.
    always_comb begin
      d = mem[a];
      if (BYPASS != 0) begin
        if (w0_ok && (wa0 == a)) d = wd0;
        if (w1_ok && (wa1 == a)) d = wd1;
      end
      if (is_r0) d = '0;
    end

    assign rd[k*XLEN +: XLEN] = d;
    assign rbusy[k]           = busy[a] && !is_r0;
  end

endmodule
